// File: rtl/sipo_n.sv
// sipo_n: serial-in / parallel-out word assembler.
//
// Bits are shifted into q on every clock edge where shift_en is high. After
// WIDTH bits, the assembled word is published on `word` and flagged by
// `word_valid`, which stays high until the consumer asserts word_ack. If a
// new word completes while the previous one is still unacknowledged, the
// old word is overwritten and the sticky `overrun` flag is set.
//
// Optional feature, compiled in with the macro SIPO_PARITY_EN: every WIDTH
// data bits are followed by one even-parity bit. The word is published on
// that parity edge, and parity_err reports whether the parity check failed.
// Without the macro, parity_err is tied to 0.
//
// clear is a synchronous, active-high reset with priority over all other
// inputs.
module sipo_n #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       clear,
  input  logic                       datain,
  input  logic                       shift_en,
  input  logic                       word_ack,
  output logic [WIDTH-1:0]           q,
  output logic [WIDTH-1:0]           word,
  output logic                       word_valid,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
  output logic                       overrun,
  output logic                       parity_err
);

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    PARITY  = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shifted;   // q after accepting datain in the current bit order
  logic             last_bit;  // this edge carries the WIDTH-th data bit
  logic             publish;   // this edge hands a finished word to the consumer
  logic [WIDTH-1:0] pub_word;  // value handed over when publish is high

  assign shifted  = MSB_FIRST ? {q[WIDTH-2:0], datain} : {datain, q[WIDTH-1:1]};
  assign last_bit = shift_en && (state == COLLECT) && (bit_cnt == LAST);

`ifdef SIPO_PARITY_EN
  // The word is complete only once the trailing parity bit has arrived.
  // q already holds all data bits at that point.
  assign publish  = shift_en && (state == PARITY);
  assign pub_word = q;
`else
  // The word completes on the edge that carries its last data bit.
  // That bit is included, so the new q value is published.
  assign publish  = last_bit;
  assign pub_word = shifted;
`endif

  // Frame FSM: shift data bits, count them, and step through the parity slot.
  // NOTE: sequential state uses non-blocking assignments so that every flop
  // samples pre-edge values, independent of statement or process order.
  always_ff @(posedge clk) begin
    if (clear) begin
      q       <= '0;
      bit_cnt <= '0;
      state   <= COLLECT;
    end else if (shift_en && (state == COLLECT)) begin
      q <= shifted;
      if (last_bit) begin
        bit_cnt <= '0;
`ifdef SIPO_PARITY_EN
        state   <= PARITY;
`endif
      end else begin
        bit_cnt <= bit_cnt + CW'(1);
      end
    end else if (shift_en) begin
      // Parity slot: q and bit_cnt hold.
      // The sampled bit only feeds the parity check.
      state <= COLLECT;
    end
  end

  // Word handoff: publish the word, clear it on acknowledge, and record overruns.
  always_ff @(posedge clk) begin
    if (clear) begin
      word       <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (publish) begin
      word       <= pub_word;
      word_valid <= 1'b1;
      if (word_valid && !word_ack) begin
        overrun <= 1'b1;
      end
    end else if (word_ack) begin
      word_valid <= 1'b0;
    end
  end

`ifdef SIPO_PARITY_EN
  // Even-parity check result, updated only when a word is published.
  always_ff @(posedge clk) begin
    if (clear) begin
      parity_err <= 1'b0;
    end else if (publish) begin
      parity_err <= ^{q, datain};
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_n.sv
// tb_sipo_n: self-checking bench for sipo_n.
//
// Two WIDTH=4 instances share the same stimulus: one is MSB-first, the other
// LSB-first. A behavioural model tracks the history of received bits and the
// frame position. From these it derives q, word, word_valid, bit_cnt, overrun
// and parity_err. The model is compared against both instances after every
// clock edge.
//
// Directed sequences pin the model to hand-computed literal values. A
// randomized phase follows.
//
// Compile with SIPO_PARITY_EN defined to exercise the parity variant.
module tb_sipo_n;

  localparam int W  = 4;
  localparam int CW = $clog2(W + 1);
`ifdef SIPO_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          clear = 1'b0;
  logic          datain = 1'b0;
  logic          shift_en = 1'b0;
  logic          word_ack = 1'b0;

  logic [W-1:0]  q_a, word_a, q_b, word_b;
  logic          valid_a, valid_b, ovr_a, ovr_b, perr_a, perr_b;
  logic [CW-1:0] cnt_a, cnt_b;

  sipo_n #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .clear(clear), .datain(datain), .shift_en(shift_en), .word_ack(word_ack),
    .q(q_a), .word(word_a), .word_valid(valid_a), .bit_cnt(cnt_a),
    .overrun(ovr_a), .parity_err(perr_a)
  );

  sipo_n #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .clear(clear), .datain(datain), .shift_en(shift_en), .word_ack(word_ack),
    .q(q_b), .word(word_b), .word_valid(valid_b), .bit_cnt(cnt_b),
    .overrun(ovr_b), .parity_err(perr_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit        hist[$];        // data bits received since the last clear, oldest first
  int        frame_bits;     // data bits received in the current frame
  bit        in_parity;      // next shift edge carries the parity bit
  bit [W-1:0] m_word_a, m_word_b;
  bit        m_valid, m_ovr, m_perr;
  bit        model_live = 1'b0;

  // Register contents: the last W bits received.
  // In MSB-first order the newest bit sits at index 0; in LSB-first order it
  // sits at index W-1.
  function automatic bit [W-1:0] qval(input bit msb);
    bit [W-1:0] v = '0;
    int n = hist.size();
    for (int i = 0; i < W; i++) begin
      bit b = (i < n) ? hist[n-1-i] : 1'b0;
      if (msb) v[i] = b;
      else     v[W-1-i] = b;
    end
    return v;
  endfunction

  // Advance the model on each edge, then compare once the outputs have settled.
  always @(posedge clk) begin
    bit pub;
    bit [W-1:0] na, nb;
    pub = 1'b0;
    na  = '0;
    nb  = '0;
    if (clear) begin
      hist.delete();
      frame_bits = 0;
      in_parity  = 1'b0;
      m_word_a   = '0;
      m_word_b   = '0;
      m_valid    = 1'b0;
      m_ovr      = 1'b0;
      m_perr     = 1'b0;
      model_live = 1'b1;
    end else begin
      if (shift_en) begin
        if (in_parity) begin
          pub       = 1'b1;
          na        = qval(1'b1);
          nb        = qval(1'b0);
          m_perr    = (^na) ^ datain;
          in_parity = 1'b0;
        end else begin
          hist.push_back(datain);
          if (hist.size() > W) void'(hist.pop_front());
          frame_bits++;
          if (frame_bits == W) begin
            frame_bits = 0;
            if (PAR) begin
              in_parity = 1'b1;
            end else begin
              pub = 1'b1;
              na  = qval(1'b1);
              nb  = qval(1'b0);
            end
          end
        end
      end
      if (pub) begin
        if (m_valid && !word_ack) m_ovr = 1'b1;
        m_word_a = na;
        m_word_b = nb;
        m_valid  = 1'b1;
      end else if (word_ack) begin
        m_valid = 1'b0;
      end
    end
    #1;
    if (model_live) begin
      check("q_msb",      32'(q_a),     32'(qval(1'b1)));
      check("q_lsb",      32'(q_b),     32'(qval(1'b0)));
      check("word_msb",   32'(word_a),  32'(m_word_a));
      check("word_lsb",   32'(word_b),  32'(m_word_b));
      check("valid_msb",  32'(valid_a), 32'(m_valid));
      check("valid_lsb",  32'(valid_b), 32'(m_valid));
      check("bitcnt_msb", 32'(cnt_a),   32'(frame_bits));
      check("bitcnt_lsb", 32'(cnt_b),   32'(frame_bits));
      check("overrun",    32'(ovr_a),   32'(m_ovr));
      check("overrun_b",  32'(ovr_b),   32'(m_ovr));
      check("parity_err", 32'(perr_a),  32'(m_perr));
      check("parity_errb",32'(perr_b),  32'(m_perr));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit c, input bit s, input bit d, input bit a);
    @(negedge clk);
    clear    = c;
    shift_en = s;
    datain   = d;
    word_ack = a;
  endtask

  // Wait for the edge that applies the last driven inputs, then let it settle.
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Send one word (first bit = w[W-1]).
  // In the parity build, append parity bit p.
  // ack is asserted on the completing edge when ack_last is set.
  task automatic send_word(input logic [W-1:0] w, input bit p, input bit ack_last);
    for (int i = W - 1; i >= 0; i--)
      drive(1'b0, 1'b1, w[i], (i == 0 && !PAR) ? ack_last : 1'b0);
    if (PAR) drive(1'b0, 1'b1, p, ack_last);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [W-1:0] w;

    drive(1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    check("rst_q",      32'(q_a),     32'h0);
    check("rst_word",   32'(word_a),  32'h0);
    check("rst_valid",  32'(valid_a), 32'h0);
    check("rst_bitcnt", 32'(cnt_a),   32'h0);
    check("rst_ovr",    32'(ovr_a),   32'h0);
    check("rst_perr",   32'(perr_a),  32'h0);

    // Bits 1,0,1,1: MSB-first gives 1011, LSB-first gives 1101.
    w = 4'b1011;
    for (int i = W - 1; i >= 0; i--) drive(1'b0, 1'b1, w[i], 1'b0);
    settle();
    check("lit_bitcnt_after4", 32'(cnt_a), 32'h0);
    if (PAR) begin
      check("lit_valid_before_parity", 32'(valid_a), 32'h0);
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      settle();
      check("lit_perr_good", 32'(perr_a), 32'h0);
    end
    check("lit_word_msb", 32'(word_a),  32'hB);
    check("lit_word_lsb", 32'(word_b),  32'hD);
    check("lit_valid",    32'(valid_a), 32'h1);

    // Acknowledge.
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    settle();
    check("lit_ack_clears", 32'(valid_a), 32'h0);

    // Gapped frame 0,1,[gap x3],1,0.
    // MSB-first q: 1011 -> 0110 -> 1101.
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    settle();
    check("lit_gap_bitcnt", 32'(cnt_a), 32'h2);
    check("lit_gap_q",      32'(q_a),   32'hD);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    if (PAR) drive(1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    check("lit_gap_word", 32'(word_a), 32'h6);

    // Second word without ack gives overrun.
    // A third word completes together with ack, so valid stays 1.
    send_word(4'b1001, 1'b0, 1'b0);
    settle();
    check("lit_ovr_set",  32'(ovr_a),  32'h1);
    check("lit_ovr_word", 32'(word_a), 32'h9);
    send_word(4'b0011, 1'b0, 1'b1);
    settle();
    check("lit_ack_collide_valid", 32'(valid_a), 32'h1);
    check("lit_ack_collide_word",  32'(word_a),  32'h3);
    check("lit_ovr_sticky",        32'(ovr_a),   32'h1);

    // Clear after 2 of 4 bits.
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    settle();
    check("lit_clr_q",      32'(q_a),     32'h0);
    check("lit_clr_word",   32'(word_a),  32'h0);
    check("lit_clr_valid",  32'(valid_a), 32'h0);
    check("lit_clr_bitcnt", 32'(cnt_a),   32'h0);
    check("lit_clr_ovr",    32'(ovr_a),   32'h0);
    send_word(4'b1100, 1'b0, 1'b0);
    settle();
    check("lit_post_clr_msb", 32'(word_a), 32'hC);
    check("lit_post_clr_lsb", 32'(word_b), 32'h3);

    // Bad parity: 1011 followed by parity bit 0.
    if (PAR) begin
      send_word(4'b1011, 1'b0, 1'b1);
      settle();
      check("lit_perr_bad", 32'(perr_a), 32'h1);
    end

    // Randomized phase; the compare process checks every edge.
    for (int n = 0; n < 3000; n++)
      drive(($urandom % 64) == 0, ($urandom % 10) < 7, 1'($urandom_range(0, 1)),
            ($urandom % 4) == 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
